// File: rtl/arb_request_agent.sv
// Requester-side agent for a round-robin arbiter: buffers producer words in a FIFO,
// requests while non-empty, and drives one registered word per granted cycle.
module arb_request_agent #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int PTR_WIDTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  req,
   input  logic                  grant,
   output logic                  bus_valid,
   output logic [DATA_WIDTH-1:0] bus_data,
   output logic [PTR_WIDTH:0]    count,
   output logic                  proto_err
);

   localparam logic [PTR_WIDTH:0]   DEPTH_C = (PTR_WIDTH+1)'(FIFO_DEPTH);
   localparam logic [PTR_WIDTH:0]   CNT_ONE = (PTR_WIDTH+1)'(1);
   localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
   logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_WIDTH:0]    count_q, count_d;
   logic                  bus_valid_q, bus_valid_d;
   logic [DATA_WIDTH-1:0] bus_data_q, bus_data_d;
   logic                  proto_err_q, proto_err_d;
   logic                  push;
   logic                  pop;

   // req must never depend on grant: the arbiter's grant is combinational on req.
   assign req       = (count_q != '0);
   assign in_ready  = (count_q != DEPTH_C);
   assign push      = in_valid && in_ready;
   assign pop       = req && grant;
   assign bus_valid = bus_valid_q;
   assign bus_data  = bus_data_q;
   assign count     = count_q;
   assign proto_err = proto_err_q;

   always_comb begin
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      bus_valid_d = 1'b0;
      bus_data_d  = bus_data_q;
      proto_err_d = proto_err_q | (grant & ~req);

      if (push) begin
         mem_d[wr_ptr_q] = in_data;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end

      if (pop) begin
         bus_valid_d = 1'b1;
         bus_data_d  = mem_q[rd_ptr_q];
         rd_ptr_d    = rd_ptr_q + PTR_ONE;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         bus_valid_q <= 1'b0;
         bus_data_q  <= '0;
         proto_err_q <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         bus_valid_q <= bus_valid_d;
         bus_data_q  <= bus_data_d;
         proto_err_q <= proto_err_d;
      end
   end

endmodule

// File: tb/tb_arb_request_agent.sv
// Bench for arb_request_agent: directed vector table, async reset, a four-agent
// round-robin system, and randomized traffic against a queue-based reference model.
module tb_arb_request_agent;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        req;
   logic        grant;
   logic        bus_valid;
   logic [31:0] bus_data;
   logic [2:0]  count;
   logic        proto_err;

   int checks;
   int errors;

   arb_request_agent #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .PTR_WIDTH(2)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .req(req), .grant(grant), .bus_valid(bus_valid),
      .bus_data(bus_data), .count(count), .proto_err(proto_err)
   );

   // Four-agent system sharing a bench-side round-robin arbiter
   logic [3:0]  sys_valid;
   logic [31:0] sys_din [4];
   logic [3:0]  sys_ready;
   logic [3:0]  sys_req;
   logic [3:0]  sys_grant;
   logic [3:0]  sys_bv;
   logic [31:0] sys_bd [4];
   logic [2:0]  sys_cnt [4];
   logic [3:0]  sys_perr;
   logic        arb_en;
   logic [1:0]  arb_last;
   int          arb_sel;

   for (genvar a = 0; a < 4; a++) begin : g_sys
      arb_request_agent #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .PTR_WIDTH(2)) u_agent (
         .clk(clk), .rst(rst), .in_valid(sys_valid[a]), .in_data(sys_din[a]),
         .in_ready(sys_ready[a]), .req(sys_req[a]), .grant(sys_grant[a]),
         .bus_valid(sys_bv[a]), .bus_data(sys_bd[a]), .count(sys_cnt[a]),
         .proto_err(sys_perr[a])
      );
   end

   always_comb begin
      sys_grant = '0;
      arb_sel   = 0;
      if (arb_en) begin
         for (int k = 1; k <= 4; k++) begin
            if (sys_grant == 4'b0 && sys_req[(int'(arb_last) + k) % 4]) begin
               arb_sel = (int'(arb_last) + k) % 4;
               sys_grant[arb_sel] = 1'b1;
            end
         end
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) arb_last <= 2'd3;
      else if (|sys_grant) arb_last <= arb_sel[1:0];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [31:0] d;
      logic        g;
      logic        ebv;
      logic [31:0] ebd;
      logic [2:0]  ecnt;
      logic        ereq;
      logic        erdy;
      logic        eperr;
   } vec_t;

   vec_t vecs[$];

   task automatic addVec(input logic v, input logic [31:0] d, input logic g,
                         input logic ebv, input logic [31:0] ebd, input logic [2:0] ecnt,
                         input logic ereq, input logic erdy, input logic eperr);
      vec_t t;
      t.v = v; t.d = d; t.g = g; t.ebv = ebv; t.ebd = ebd;
      t.ecnt = ecnt; t.ereq = ereq; t.erdy = erdy; t.eperr = eperr;
      vecs.push_back(t);
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] d, input logic g);
      in_valid = v;
      in_data  = d;
      grant    = g;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkAll(input string tag, input logic ebv, input logic [31:0] ebd,
                           input logic [2:0] ecnt, input logic ereq, input logic erdy,
                           input logic eperr);
      checkOutput({tag, " bus_valid"}, 32'(bus_valid), 32'(ebv));
      checkOutput({tag, " bus_data"},  bus_data, ebd);
      checkOutput({tag, " count"},     32'(count), 32'(ecnt));
      checkOutput({tag, " req"},       32'(req), 32'(ereq));
      checkOutput({tag, " in_ready"},  32'(in_ready), 32'(erdy));
      checkOutput({tag, " proto_err"}, 32'(proto_err), 32'(eperr));
   endtask

   logic [31:0] model_q[$];
   logic [31:0] m_bd;
   logic        m_bv;
   logic        m_perr;
   int          exp_k [4];
   int          pulses;
   int          kmax;
   int          kmin;

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; grant = 1'b0;
      sys_valid = '0; arb_en = 1'b0;
      for (int a = 0; a < 4; a++) sys_din[a] = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      checkAll("reset", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0);

      // Single word, fill to full (refused push during pop), wrap, concurrent push/pop, proto error
      addVec(1, 32'hA5A50001, 0,  0, 32'h0,        1, 1, 1, 0);
      addVec(0, 32'h0,        1,  1, 32'hA5A50001, 0, 0, 1, 0);
      addVec(0, 32'h0,        0,  0, 32'hA5A50001, 0, 0, 1, 0);
      addVec(1, 32'h10,       0,  0, 32'hA5A50001, 1, 1, 1, 0);
      addVec(1, 32'h11,       0,  0, 32'hA5A50001, 2, 1, 1, 0);
      addVec(1, 32'h12,       0,  0, 32'hA5A50001, 3, 1, 1, 0);
      addVec(1, 32'h13,       0,  0, 32'hA5A50001, 4, 1, 0, 0);
      addVec(1, 32'h14,       1,  1, 32'h10,       3, 1, 1, 0);
      addVec(0, 32'h0,        1,  1, 32'h11,       2, 1, 1, 0);
      addVec(0, 32'h0,        1,  1, 32'h12,       1, 1, 1, 0);
      addVec(0, 32'h0,        1,  1, 32'h13,       0, 0, 1, 0);
      addVec(0, 32'h0,        0,  0, 32'h13,       0, 0, 1, 0);
      addVec(1, 32'h20,       0,  0, 32'h13,       1, 1, 1, 0);
      addVec(1, 32'h21,       0,  0, 32'h13,       2, 1, 1, 0);
      addVec(1, 32'h22,       0,  0, 32'h13,       3, 1, 1, 0);
      addVec(0, 32'h0,        1,  1, 32'h20,       2, 1, 1, 0);
      addVec(0, 32'h0,        1,  1, 32'h21,       1, 1, 1, 0);
      addVec(0, 32'h0,        1,  1, 32'h22,       0, 0, 1, 0);
      addVec(1, 32'h30,       0,  0, 32'h22,       1, 1, 1, 0);
      addVec(1, 32'h31,       0,  0, 32'h22,       2, 1, 1, 0);
      addVec(1, 32'h32,       1,  1, 32'h30,       2, 1, 1, 0);
      addVec(1, 32'h33,       1,  1, 32'h31,       2, 1, 1, 0);
      addVec(1, 32'h34,       1,  1, 32'h32,       2, 1, 1, 0);
      addVec(1, 32'h35,       1,  1, 32'h33,       2, 1, 1, 0);
      addVec(1, 32'h36,       1,  1, 32'h34,       2, 1, 1, 0);
      addVec(0, 32'h0,        1,  1, 32'h35,       1, 1, 1, 0);
      addVec(0, 32'h0,        1,  1, 32'h36,       0, 0, 1, 0);
      addVec(0, 32'h0,        1,  0, 32'h36,       0, 0, 1, 1);
      addVec(1, 32'h40,       0,  0, 32'h36,       1, 1, 1, 1);
      addVec(0, 32'h0,        1,  1, 32'h40,       0, 0, 1, 1);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].v, vecs[i].d, vecs[i].g);
         checkAll($sformatf("vec%0d", i), vecs[i].ebv, vecs[i].ebd, vecs[i].ecnt,
                  vecs[i].ereq, vecs[i].erdy, vecs[i].eperr);
      end

      // Async reset mid-cycle while a word is buffered and bus_valid is high
      applyStimulus(1, 32'h50, 0);
      applyStimulus(1, 32'h51, 0);
      applyStimulus(0, 32'h0, 1);
      checkAll("pre_rst", 1'b1, 32'h50, 3'd1, 1'b1, 1'b1, 1'b1);
      #3 rst = 1'b1;
      #1;
      checkAll("async_rst", 1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0);
      in_valid = 1'b0; grant = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 32'h0, 0);
         checkAll($sformatf("post_rst%0d", i), 1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0);
      end

      // Four-agent round robin: preload 3 words each with the arbiter disabled
      for (int k = 0; k < 3; k++) begin
         sys_valid = 4'hF;
         for (int a = 0; a < 4; a++) sys_din[a] = 32'h100 * a + k;
         @(posedge clk);
         #1;
      end
      sys_valid = '0;
      for (int a = 0; a < 4; a++) begin
         checkOutput($sformatf("sys_preload%0d", a), 32'(sys_cnt[a]), 32'd3);
         exp_k[a] = 0;
      end
      arb_en = 1'b1;
      pulses = 0;
      for (int c = 0; c < 40 && pulses < 12; c++) begin
         @(posedge clk);
         #1;
         checkOutput("sys_one_pulse", 32'($countones(sys_bv) <= 1), 32'd1);
         for (int a = 0; a < 4; a++) begin
            if (sys_bv[a]) begin
               checkOutput($sformatf("sys_order%0d", a), sys_bd[a], 32'h100 * a + exp_k[a]);
               exp_k[a]++;
               pulses++;
               kmax = exp_k[0]; kmin = exp_k[0];
               for (int b = 1; b < 4; b++) begin
                  if (exp_k[b] > kmax) kmax = exp_k[b];
                  if (exp_k[b] < kmin) kmin = exp_k[b];
               end
               checkOutput("sys_fair", 32'(kmax - kmin <= 1), 32'd1);
            end
         end
      end
      checkOutput("sys_pulses", pulses, 32'd12);
      @(posedge clk);
      #1;
      checkOutput("sys_perr", 32'(sys_perr), 32'd0);
      checkOutput("sys_idle_bv", 32'(sys_bv), 32'd0);
      arb_en = 1'b0;

      // Randomized traffic against a queue model of the agent
      model_q.delete();
      m_bd = 32'h0;
      m_perr = 1'b0;
      for (int i = 0; i < 400; i++) begin
         logic        v;
         logic [31:0] d;
         logic        g;
         v = 1'($urandom_range(0, 1));
         d = $urandom;
         if (model_q.size() != 0) g = ($urandom_range(0, 2) != 0);
         else g = ($urandom_range(0, 19) == 0);
         m_bv = 1'b0;
         if (g && model_q.size() != 0) begin
            m_bd = model_q.pop_front();
            m_bv = 1'b1;
         end else if (g) begin
            m_perr = 1'b1;
         end
         if (v && (model_q.size() + (m_bv ? 1 : 0)) != 4) model_q.push_back(d);
         applyStimulus(v, d, g);
         checkAll($sformatf("rnd%0d", i), m_bv, m_bd, 3'(model_q.size()),
                  model_q.size() != 0, model_q.size() != 4, m_perr);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
